// File: rtl/system_0_sysid_ext.sv
// System ID / uptime slave: ID and build stamp, 64-bit uptime with coherent
// high-word snapshot, byte-writable scratch, sticky wrap flag, fixed read latency.
module system_0_sysid_ext #(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd1765936223,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int unsigned DEPTH =
    (READ_LATENCY < 1) ? 1 :
    (READ_LATENCY > 4) ? 4 : READ_LATENCY;
  localparam logic [2:0] LAT_FIELD = 3'(DEPTH);

  localparam logic [2:0] A_ID   = 3'd0;
  localparam logic [2:0] A_TS   = 3'd1;
  localparam logic [2:0] A_UPLO = 3'd2;
  localparam logic [2:0] A_UPHI = 3'd3;
  localparam logic [2:0] A_SCR0 = 3'd4;
  localparam logic [2:0] A_SCR1 = 3'd5;
  localparam logic [2:0] A_STAT = 3'd6;

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] scr0_q, scr0_d;
  logic [31:0] scr1_q, scr1_d;
  logic        wrap_q, wrap_d;
  logic        wrap_set;

  logic [DEPTH-1:0]       vld_q;
  logic [DEPTH-1:0][31:0] dat_q;
  logic [31:0]            rdata;

  logic wr_lo, wr_hi, wr_s0, wr_s1, wr_st;
  logic rd_lo;

  assign wr_lo = write && (address == A_UPLO);
  assign wr_hi = write && (address == A_UPHI);
  assign wr_s0 = write && (address == A_SCR0);
  assign wr_s1 = write && (address == A_SCR1);
  assign wr_st = write && (address == A_STAT);
  assign rd_lo = read  && (address == A_UPLO);

  // A load replaces one half and takes the place of that cycle's increment.
  always_comb begin
    cnt_d    = cnt_q + 64'd1;
    wrap_set = (cnt_q == '1);
    if (wr_lo) begin
      cnt_d    = {cnt_q[63:32], writedata};
      wrap_set = 1'b0;
    end else if (wr_hi) begin
      cnt_d    = {writedata, cnt_q[31:0]};
      wrap_set = 1'b0;
    end
  end

  always_comb begin
    wrap_d = wrap_q;
    if (wr_st && writedata[8]) wrap_d = 1'b0;
    if (wrap_set) wrap_d = 1'b1;
  end

  always_comb begin
    snap_d = snap_q;
    if (rd_lo) snap_d = cnt_q[63:32];
  end

  always_comb begin
    scr0_d = scr0_q;
    scr1_d = scr1_q;
    for (int b = 0; b < 4; b++) begin
      if (wr_s0 && byteenable[b])
        scr0_d[8*b +: 8] = writedata[8*b +: 8];
      if (wr_s1 && byteenable[b])
        scr1_d[8*b +: 8] = writedata[8*b +: 8];
    end
  end

  always_comb begin
    rdata = 32'd0;
    unique case (address)
      A_ID:    rdata = ID_VALUE;
      A_TS:    rdata = TIMESTAMP;
      A_UPLO:  rdata = cnt_q[31:0];
      A_UPHI:  rdata = snap_q;
      A_SCR0:  rdata = scr0_q;
      A_SCR1:  rdata = scr1_q;
      A_STAT:  rdata = {23'd0, wrap_q, 5'd0, LAT_FIELD};
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      snap_q <= '0;
      scr0_q <= '0;
      scr1_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      scr0_q <= scr0_d;
      scr1_q <= scr1_d;
      wrap_q <= wrap_d;
    end
  end

  // Data is zeroed on entry when no read, so the output needs no gating.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= read;
      dat_q[0] <= read ? rdata : 32'd0;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign readdata      = dat_q[DEPTH-1];
  assign readdatavalid = vld_q[DEPTH-1];

endmodule
